// File: rtl/ecc_pkg.sv
// ecc_pkg
//   Shared definitions for the ECC arithmetic blocks:
//   - mode_e  : operation select for mont_mul_ws
//   - state_e : controller states of mont_mul_ws
//   - P-256 domain constants (modulus, Montgomery constants, curve a/b, base point)
package ecc_pkg;

  typedef enum logic [1:0] {
    MODE_MUL       = 2'd0,
    MODE_TO_MONT   = 2'd1,
    MODE_FROM_MONT = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_AB    = 2'd1,
    S_MP    = 2'd2,
    S_FINAL = 2'd3
  } state_e;

  // p = 2^256 - 2^224 + 2^192 + 2^96 - 1
  localparam logic [255:0] P256_P =
    256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;
  // -p^-1 mod 2^256
  localparam logic [255:0] P256_P_PRIME =
    256'hffffffff00000002000000000000000000000001000000000000000000000001;
  // R^2 mod p with R = 2^256
  localparam logic [255:0] P256_R2 =
    256'h00000004fffffffdfffffffffffffffefffffffbffffffff0000000000000003;
  // curve coefficients (a = p - 3)
  localparam logic [255:0] P256_A =
    256'hffffffff00000001000000000000000000000000fffffffffffffffffffffffc;
  localparam logic [255:0] P256_B =
    256'h5ac635d8aa3a93e7b3ebbd55769886bc651d06b0cc53b0f63bce3c3e27d2604b;
  // base point
  localparam logic [255:0] P256_GX =
    256'h6b17d1f2e12c4247f8bce6e563a440f277037d812deb33a0f4a13945d898c296;
  localparam logic [255:0] P256_GY =
    256'h4fe342e2fe1a7f9b8ee7eb4a7c0f9e162bce33576b315ececbb6406837bf51f5;

endpackage

// File: rtl/mont_digit_mac.sv
// mont_digit_mac
//   Combinational digit multiply-accumulate: sum = acc + x * y.
//   Shared by both phases of mont_mul_ws: in the AB phase x is a digit of a
//   and y is b; in the MP phase x is the reduction digit m and y is p.
// Ports:
//   x   in  W        digit operand
//   y   in  LEN      full-width operand
//   acc in  LEN+W+2  running accumulator T
//   sum out LEN+W+2  acc + x*y (cannot overflow while T < 2p holds)
module mont_digit_mac #(
  parameter int LEN = 256,
  parameter int W   = 32
) (
  input  logic [W-1:0]     x,
  input  logic [LEN-1:0]   y,
  input  logic [LEN+W+1:0] acc,
  output logic [LEN+W+1:0] sum
);

  localparam int TW = LEN + W + 2;

  always_comb begin
    sum = acc + (TW'(x) * TW'(y));
  end

endmodule

// File: rtl/mont_mul_ws.sv
// mont_mul_ws
//   Word-serial Montgomery multiplier: res = a * b_eff * 2^-LEN mod p.
//   b_eff is b (MUL), r2_mod_p (TO_MONT) or 1 (FROM_MONT). One digit of a
//   (W bits, LSB first) is consumed per AB/MP cycle pair, giving a fixed
//   latency of 2N+2 cycles from the accepting edge to the done pulse.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   enable       start request, sampled only in IDLE
//   mode         0 MUL, 1 TO_MONT, 2 FROM_MONT, 3 behaves as MUL
//   a, b, p      operands and odd modulus (a, b < p)
//   p_prime      -p^-1 mod 2^LEN, only the low W bits are used
//   r2_mod_p     R^2 mod p, used by TO_MONT
//   res          result, < p, updated with done
//   busy         high while an operation is in flight
//   done         one-cycle pulse when res updates
//   valid        high from done until the next accepted start or reset
module mont_mul_ws
  import ecc_pkg::*;
#(
  parameter int LEN = 256,
  parameter int W   = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           enable,
  input  logic [1:0]     mode,
  input  logic [LEN-1:0] a,
  input  logic [LEN-1:0] b,
  input  logic [LEN-1:0] p,
  input  logic [LEN-1:0] p_prime,
  input  logic [LEN-1:0] r2_mod_p,
  output logic [LEN-1:0] res,
  output logic           busy,
  output logic           done,
  output logic           valid
);

  localparam int N     = LEN / W;
  localparam int TW    = LEN + W + 2;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (LEN % W != 0) begin : g_len_check
      $error("mont_mul_ws: LEN must be a multiple of W");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN-1:0]   a_q, a_d;      // shifts right one digit per MP phase
  logic [LEN-1:0]   b_q, b_d;      // effective multiplier
  logic [LEN-1:0]   p_q, p_d;
  logic [W-1:0]     n0_q, n0_d;
  logic [TW-1:0]    t_q, t_d;
  logic [LEN-1:0]   res_q, res_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;

  logic [W-1:0]     mp_digit;
  logic [W-1:0]     mac_x;
  logic [LEN-1:0]   mac_y;
  logic [TW-1:0]    mac_sum;

  // Only the low digit of p_prime matters; the rest is deliberately ignored.
  logic unused_p_prime;
  assign unused_p_prime = ^p_prime;

  // Operand mux: AB adds a_i*b, MP adds m*p. m only needs the low W bits.
  always_comb begin
    mp_digit = t_q[W-1:0] * n0_q;
    mac_x    = a_q[W-1:0];
    mac_y    = b_q;
    if (state_q == S_MP) begin
      mac_x = mp_digit;
      mac_y = p_q;
    end
  end

  mont_digit_mac #(
    .LEN (LEN),
    .W   (W)
  ) u_mac (
    .x   (mac_x),
    .y   (mac_y),
    .acc (t_q),
    .sum (mac_sum)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    n0_d    = n0_q;
    t_d     = t_q;
    res_d   = res_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          a_d  = a;
          p_d  = p;
          n0_d = p_prime[W-1:0];
          case (mode)
            MODE_TO_MONT:   b_d = r2_mod_p;
            MODE_FROM_MONT: b_d = LEN'(1);
            default:        b_d = b;
          endcase
          t_d     = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          state_d = S_AB;
        end
      end

      S_AB: begin
        t_d     = mac_sum;
        state_d = S_MP;
      end

      S_MP: begin
        // Low W bits of mac_sum are zero by choice of m; drop them.
        t_d = mac_sum >> W;
        a_d = a_q >> W;
        if (cnt_q == CNT_W'(N - 1)) begin
          cnt_d   = '0;
          state_d = S_FINAL;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_AB;
        end
      end

      S_FINAL: begin
        // T < 2p, so one conditional subtract fully reduces and T - p fits LEN bits.
        if (t_q >= TW'(p_q)) begin
          res_d = t_q[LEN-1:0] - p_q;
        end else begin
          res_d = t_q[LEN-1:0];
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      n0_q    <= '0;
      t_q     <= '0;
      res_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      n0_q    <= n0_d;
      t_q     <= t_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
    end
  end

  assign res   = res_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign valid = valid_q;

endmodule
